// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI-to-ALU transaction bridge.
// Holds the FSM state encoding, command/status bit positions and opcode values.
// Status byte layout: {busy, done, frame_err, overrun, timeout, 3'b000}.
package spi_alu_pkg;

  localparam int CMD_W    = 8;
  localparam int EXEC_BIT = 7;

  localparam int STATUS_BUSY = 7;
  localparam int STATUS_DONE = 6;
  localparam int STATUS_FERR = 5;
  localparam int STATUS_OVR  = 4;
  localparam int STATUS_TMO  = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Assemble the status byte returned at the head of every frame.
  function automatic logic [CMD_W-1:0] pack_status(input logic busy, input logic done,
                                                   input logic ferr, input logic ovr,
                                                   input logic tmo);
    logic [CMD_W-1:0] s;
    s              = '0;
    s[STATUS_BUSY] = busy;
    s[STATUS_DONE] = done;
    s[STATUS_FERR] = ferr;
    s[STATUS_OVR]  = ovr;
    s[STATUS_TMO]  = tmo;
    return s;
  endfunction

endpackage

// File: rtl/spi_target_phy.sv
// SPI mode-0 target front end: synchronisers, edge detection, rx/tx shifters, bit counter.
// Latency: SPI pin change visible as an edge pulse SYNC_STAGES+1 clk later.
// No backpressure: the host clocks bits freely; f_clk must be >= 4x SCLK.
module spi_target_phy
  import spi_alu_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OPC_W       = 3,
  parameter int RX_W        = 64,
  parameter int TX_W        = 72,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_clk_i,
  input  logic             spi_cs_i,
  input  logic             spi_pico_i,
  output logic             spi_poci_o,
  input  logic [TX_W-1:0]  load_word_i,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic             cmd_exec_o,
  output logic [OPC_W-1:0] cmd_op_o,
  output logic [RX_W-1:0]  rx_data_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, pico_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, pico_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [CMD_W-1:0]       cmd_q;
  logic [RX_W-1:0]        rx_q;
  logic [TX_W-1:0]        tx_q;
  logic [CNT_W-1:0]       bit_cnt_q;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign pico_s = pico_sync_q[SYNC_STAGES-1];

  // Bring the SPI pins into the clk domain; CS idles high so reset never fakes a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      pico_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      pico_sync_q <= {pico_sync_q[SYNC_STAGES-2:0], spi_pico_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // SCLK edges only count inside a frame; PICO shares the SCLK pipeline depth so stays aligned.
  assign sclk_rise = ~sclk_prev_q &  sclk_s & ~cs_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s & ~cs_s;
  assign cs_fall   =  cs_prev_q   & ~cs_s;
  assign cs_rise   = ~cs_prev_q   &  cs_s;

  // Shift engine: load reply at frame start, sample on rise, advance POCI on fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      bit_cnt_q <= '0;
    end else if (cs_fall) begin
      cmd_q     <= '0;
      rx_q      <= '0;
      tx_q      <= load_word_i;
      bit_cnt_q <= '0;
    end else if (cs_rise) begin
      // Park POCI low between frames; rx/cmd/bit_cnt stay put for the decoder.
      tx_q <= '0;
    end else begin
      if (sclk_rise) begin
        rx_q <= {rx_q[RX_W-2:0], pico_s};
        if (bit_cnt_q < CNT_W'(CMD_W)) begin
          cmd_q <= {cmd_q[CMD_W-2:0], pico_s};
        end
        if (bit_cnt_q != '1) begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
      if (sclk_fall) begin
        tx_q <= {tx_q[TX_W-2:0], 1'b0};
      end
    end
  end

  assign spi_poci_o    = tx_q[TX_W-1];
  assign frame_start_o = cs_fall;
  assign frame_end_o   = cs_rise;
  assign bit_cnt_o     = bit_cnt_q;
  assign cmd_exec_o    = cmd_q[EXEC_BIT];
  assign cmd_op_o      = cmd_q[OPC_W-1:0];
  assign rx_data_o     = rx_q;

endmodule

// File: rtl/spi_alu_bridge.sv
// SPI command frames -> sequenced multi-cycle ALU transaction with sticky status reporting.
// Latency: CS-rise edge detect to alu_start is one clk; result appears on the next frame.
// A frame ending while an op is in flight is dropped and flagged as overrun; no stalling.
module spi_alu_bridge
  import spi_alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RES_W       = 64,
  parameter int OPC_W       = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SPI_CLK,
  input  logic              SPI_CS,
  input  logic              SPI_PICO,
  output logic              SPI_POCI,
  output logic              alu_start,
  output logic [OPC_W-1:0]  alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  output logic              busy
);

  localparam int FRAME_BITS = CMD_W + 2 * DATA_W;
  localparam int TX_W       = CMD_W + RES_W;
  localparam int RX_W       = 2 * DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);

  logic              frame_start, frame_end, cmd_exec;
  logic [CNT_W-1:0]  bit_cnt;
  logic [OPC_W-1:0]  cmd_op;
  logic [RX_W-1:0]   rx_data;
  logic [TX_W-1:0]   load_word;

  state_e            state_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [RES_W-1:0]  result_q;
  logic              done_q, ferr_q, ovr_q, tmo_q, busy_q, alu_start_q;
  logic [OPC_W-1:0]  alu_op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;

  logic done_hit, tmo_hit, finishing, exec_ok, frame_bad, can_issue, issue, overrun;

  spi_target_phy #(
    .SYNC_STAGES (SYNC_STAGES),
    .OPC_W       (OPC_W),
    .RX_W        (RX_W),
    .TX_W        (TX_W),
    .CNT_W       (CNT_W)
  ) u_phy (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_clk_i     (SPI_CLK),
    .spi_cs_i      (SPI_CS),
    .spi_pico_i    (SPI_PICO),
    .spi_poci_o    (SPI_POCI),
    .load_word_i   (load_word),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end),
    .bit_cnt_o     (bit_cnt),
    .cmd_exec_o    (cmd_exec),
    .cmd_op_o      (cmd_op),
    .rx_data_o     (rx_data)
  );

  // Completion and timeout are decided in WAIT; alu_done elsewhere is ignored.
  assign done_hit  = (state_q == ST_WAIT) && alu_done;
  assign tmo_hit   = (state_q == ST_WAIT) && !alu_done && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
  assign finishing = done_hit || tmo_hit;

  // Frame-end classification; a frame ending on the completion cycle is treated as idle.
  assign exec_ok   = frame_end && cmd_exec && (bit_cnt == CNT_W'(FRAME_BITS));
  assign frame_bad = frame_end && ((bit_cnt < CNT_W'(CMD_W)) ||
                                   (cmd_exec && (bit_cnt != CNT_W'(FRAME_BITS))));
  assign can_issue = (state_q == ST_IDLE) || finishing;
  assign issue     = exec_ok && can_issue;
  assign overrun   = exec_ok && !can_issue;

  // Reply word reflects a same-cycle completion so a coincident frame start sees it.
  assign load_word = {pack_status(busy_q & ~finishing, done_q | done_hit, ferr_q, ovr_q,
                                  tmo_q | tmo_hit),
                      done_hit ? alu_result : result_q};

  // Transaction FSM with registered ALU interface, timeout counter and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmo_cnt_q   <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state_q   <= ST_WAIT;
          tmo_cnt_q <= TMO_W'(1);
        end
        ST_WAIT: begin
          if (finishing) state_q <= issue ? ST_ISSUE : ST_IDLE;
          else           tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase

      if (issue) begin
        alu_start_q <= 1'b1;
        alu_op_q    <= cmd_op;
        alu_a_q     <= rx_data[RX_W-1:DATA_W];
        alu_b_q     <= rx_data[DATA_W-1:0];
        busy_q      <= 1'b1;
      end else if (finishing) begin
        busy_q <= 1'b0;
      end

      if (done_hit)  begin
        result_q <= alu_result;
        done_q   <= 1'b1;
      end
      if (tmo_hit)   tmo_q  <= 1'b1;
      if (frame_bad) ferr_q <= 1'b1;
      if (overrun)   ovr_q  <= 1'b1;

      // The reply load has already captured the flags, so clearing wins here.
      if (frame_start) begin
        done_q <= 1'b0;
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
        tmo_q  <= 1'b0;
      end
    end
  end

  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_alu_bridge.sv
// Self-checking bench for spi_alu_bridge: SPI host driver, ALU model, scoreboard queues.
// Table-driven exec/read vectors plus sequences for cut frames, timeout, overrun, reset, race.
// ALU model: IEEE single add/sub/mul/div for ops 0-3, {a,b} passthrough otherwise.
module tb_spi_alu_bridge;
  import spi_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SPI_CLK, SPI_CS, SPI_PICO, SPI_POCI;
  logic        alu_start, alu_done, busy;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [63:0] alu_result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_total = 0;
  int starts = 0;
  int start_cyc = 0;
  int cs_rise_cyc = 0;
  int fire_cyc = -1;
  int alu_lat = 3;
  logic [63:0] manual_res = '0;
  logic [63:0] last_result = '0;

  typedef struct packed {logic [2:0] op; logic [31:0] a; logic [31:0] b;} issue_t;
  typedef struct {logic [7:0] cmd; logic [31:0] a; logic [31:0] b; logic [63:0] res;} vec_t;
  issue_t      iss_q[$];
  logic [71:0] sb_q[$];

  spi_alu_bridge #(.DATA_W(32), .RES_W(64), .OPC_W(3), .TIMEOUT_CYC(1024), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_PICO(SPI_PICO),
    .SPI_POCI(SPI_POCI), .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_total <= busy_total + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [63:0] alu_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    real x, y;
    x = f2r(a);
    y = f2r(b);
    case (op)
      OP_ADD:  return {32'd0, r2f(x + y)};
      OP_SUB:  return {32'd0, r2f(x - y)};
      OP_MUL:  return {32'd0, r2f(x * y)};
      OP_DIV:  return {32'd0, r2f(x / y)};
      default: return {a, b};
    endcase
  endfunction

  // ALU model: checks each issue against the expected-issue queue, answers after alu_lat cycles.
  initial begin
    int          cnt;
    logic [63:0] res;
    issue_t      got, e;
    cnt = 0;
    res = '0;
    got = '0;
    alu_done = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          alu_done = 1'b1;
          alu_result = res;
          if (busy === 1'b1) check("alu_operands_stable", {alu_op, alu_a, alu_b}, got);
        end
      end
      if (cyc == fire_cyc) begin
        alu_done = 1'b1;
        alu_result = manual_res;
      end
      if (alu_start === 1'b1) begin
        starts++;
        start_cyc = cyc;
        got = {alu_op, alu_a, alu_b};
        res = alu_calc(alu_op, alu_a, alu_b);
        cnt = (alu_lat > 0) ? alu_lat : 0;
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL alu_start_unexpected: got op=%0d a=%h b=%h expected no issue",
                   alu_op, alu_a, alu_b);
        end else begin
          e = iss_q.pop_front();
          check("alu_issue", got, e);
        end
      end
    end
  end

  // One SPI mode-0 frame, MSB first from tx[79]; POCI sampled at each SCLK rise into rx.
  task automatic spi_frame(input int nbits, input logic [79:0] tx, input int hp,
                           input bit fire_at_start, output logic [79:0] rx);
    rx = '0;
    @(negedge clk);
    SPI_CS = 1'b0;
    SPI_PICO = tx[79];
    if (fire_at_start) fire_cyc = cyc + 2;
    repeat (hp) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SPI_CLK = 1'b1;
      rx[79-i] = SPI_POCI;
      repeat (hp) @(negedge clk);
      SPI_CLK = 1'b0;
      if (i + 1 < nbits) SPI_PICO = tx[78-i];
      repeat (hp) @(negedge clk);
    end
    SPI_CS = 1'b1;
    SPI_PICO = 1'b0;
    cs_rise_cyc = cyc;
    repeat (8) @(negedge clk);
  endtask

  task automatic exec_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input int hp, input bit expect_issue);
    logic [79:0] rx;
    if (expect_issue) iss_q.push_back({cmd[2:0], a, b});
    spi_frame(72, {cmd, a, b, 8'h00}, hp, 1'b0, rx);
  endtask

  task automatic read_chk(input string name, input logic [7:0] st, input logic [63:0] res,
                          input bit fire);
    logic [79:0] rx;
    logic [71:0] e;
    sb_q.push_back({st, res});
    spi_frame(72, 80'h0, 4, fire, rx);
    e = sb_q.pop_front();
    check(name, rx[79:8], e);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles expected 0", busy, n);
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [79:0] rx;
    int          s0, b0;

    vt[0] = '{8'h80, 32'h3FC00000, 32'h40100000, 64'h0000_0000_4070_0000};
    vt[1] = '{8'h81, 32'h40A00000, 32'h3F800000, 64'h0000_0000_4080_0000};
    vt[2] = '{8'hFA, 32'h3FC00000, 32'h40800000, 64'h0000_0000_40C0_0000};
    vt[3] = '{8'h83, 32'h40C00000, 32'h40000000, 64'h0000_0000_4040_0000};
    vt[4] = '{8'h87, 32'h12345678, 32'h9ABCDEF0, 64'h1234_5678_9ABC_DEF0};
    vt[5] = '{8'h80, 32'hC0000000, 32'h40400000, 64'h0000_0000_3F80_0000};

    rst_n = 1'b0;
    SPI_CS = 1'b1;
    SPI_CLK = 1'b0;
    SPI_PICO = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", {SPI_POCI, alu_start, alu_op, alu_a, alu_b, busy}, 80'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Table of exec frames, each followed by a read of status and result.
    for (int i = 0; i < 6; i++) begin
      b0 = busy_total;
      exec_frame(vt[i].cmd, vt[i].a, vt[i].b, 4, 1'b1);
      wait_idle(200);
      if (i == 0) begin
        check("issue_latency_ok", 80'((start_cyc - cs_rise_cyc >= 1) &&
                                      (start_cyc - cs_rise_cyc <= 4)), 80'h1);
        check("busy_cycles", 80'(busy_total - b0), 80'd4);
      end
      read_chk($sformatf("vec%0d_read", i), 8'h40, vt[i].res, 1'b0);
      last_result = vt[i].res;
    end

    // Short, overlong and minimal frames.
    s0 = starts;
    spi_frame(40, {8'h80, 32'h3F800000, 32'h3F800000, 8'h00}, 4, 1'b0, rx);
    repeat (10) @(negedge clk);
    check("cut_frame_no_issue", 80'(starts - s0), 80'd0);
    read_chk("cut_frame_ferr", 8'h20, last_result, 1'b0);
    read_chk("ferr_sticky_clear", 8'h00, last_result, 1'b0);
    spi_frame(5, 80'h0, 4, 1'b0, rx);
    read_chk("short5_ferr", 8'h20, last_result, 1'b0);
    spi_frame(73, {8'h80, 32'h3F800000, 32'h3F800000, 8'h00}, 4, 1'b0, rx);
    read_chk("long73_ferr", 8'h20, last_result, 1'b0);
    spi_frame(8, 80'h0, 4, 1'b0, rx);
    read_chk("read8_ok", 8'h00, last_result, 1'b0);
    check("bad_frames_no_issue", 80'(starts - s0), 80'd0);

    // ALU never answers: timeout.
    alu_lat = -1;
    b0 = busy_total;
    exec_frame(8'h80, 32'h3F800000, 32'h3F800000, 4, 1'b1);
    wait_idle(1500);
    check("timeout_busy_cycles", 80'(busy_total - b0), 80'd1024);
    read_chk("timeout_status", 8'h08, last_result, 1'b0);

    // Second exec frame while the first op is in flight.
    alu_lat = 500;
    s0 = starts;
    exec_frame(vt[0].cmd, vt[0].a, vt[0].b, 4, 1'b1);
    exec_frame(8'h81, 32'h40A00000, 32'h3F800000, 2, 1'b0);
    read_chk("overrun_busy_status", 8'h90, last_result, 1'b0);
    wait_idle(600);
    check("overrun_single_issue", 80'(starts - s0), 80'd1);
    read_chk("overrun_first_result", 8'h40, vt[0].res, 1'b0);
    last_result = vt[0].res;

    // Reset during WAIT; the late alu_done must be ignored.
    alu_lat = 200;
    exec_frame(vt[1].cmd, vt[1].a, vt[1].b, 4, 1'b1);
    repeat (20) @(negedge clk);
    check("busy_before_reset", 80'(busy), 80'h1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mid_op", {SPI_POCI, alu_start, alu_op, alu_a, alu_b, busy}, 80'h0);
    rst_n = 1'b1;
    last_result = '0;
    s0 = starts;
    repeat (250) @(negedge clk);
    check("late_done_ignored", {8'(starts - s0), 7'd0, busy}, 80'h0);
    read_chk("after_reset_read", 8'h00, 64'h0, 1'b0);

    // alu_done lands on the same cycle the frame start loads the reply.
    alu_lat = -1;
    exec_frame(vt[0].cmd, vt[0].a, vt[0].b, 4, 1'b1);
    repeat (10) @(negedge clk);
    manual_res = 64'hDEAD_BEEF_0123_4567;
    read_chk("done_on_cs_fall", 8'h40, manual_res, 1'b1);
    last_result = manual_res;
    read_chk("after_race_read", 8'h00, manual_res, 1'b0);
    check("pending_issues_empty", 80'(iss_q.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
